// File: rtl/rv32i_decode_pkg.sv
// Shared definitions for the RV32I decode block: major opcodes and the
// instruction-format classification used to steer field and immediate decode.
package rv32i_decode_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_X
  } fmt_e;

endpackage

// File: rtl/rv32i_decode_imm.sv
// Immediate generator: assembles the sign-extended immediate for the
// instruction format chosen by the decoder. R-format and unknown give zero.
module imm_gen
  import rv32i_decode_pkg::*;
(
  input  logic [31:0] ir,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  // The low opcode bits never contribute to any immediate.
  logic unused_ir_lo;
  assign unused_ir_lo = ^ir[6:0];

  // Select and sign-extend the immediate bit-scatter for each format.
  always_comb begin
    imm = 32'h0;
    case (fmt)
      FMT_I:   imm = {{20{ir[31]}}, ir[31:20]};
      FMT_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      FMT_U:   imm = {ir[31:12], 12'h000};
      FMT_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_decode.sv
// RV32I instruction decode. Purely combinational field/immediate decode; the
// clock and reset only serve the sticky illegal-instruction flag.
// Build option: define ID_ILLEGAL_CHECK_EN to implement illegal-encoding
// detection and the illegal_seen register; otherwise both are tied low.
module rv32i_decode
  import rv32i_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        wr_reg_n,
  output logic        illegal,
  output logic        illegal_seen
);

  fmt_e       fmt;
  logic [2:0] f3_raw;
  logic [6:0] f7_raw;
  logic       writes_rd;
  logic       shift_imm;

  assign opcode = ir[6:0];
  assign f3_raw = ir[14:12];
  assign f7_raw = ir[31:25];

  // Classify the instruction format and whether the opcode writes rd.
  always_comb begin
    fmt       = FMT_X;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:               begin fmt = FMT_U; writes_rd = 1'b1; end
      OPC_JAL:                          begin fmt = FMT_J; writes_rd = 1'b1; end
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:   begin fmt = FMT_I; writes_rd = 1'b1; end
      OPC_MISC_MEM, OPC_SYSTEM:         fmt = FMT_I;
      OPC_BRANCH:                       fmt = FMT_B;
      OPC_STORE:                        fmt = FMT_S;
      OPC_OP:                           begin fmt = FMT_R; writes_rd = 1'b1; end
      default:                          fmt = FMT_X;
    endcase
  end

  // Shift-immediate ops carry a funct7 in the upper immediate bits.
  assign shift_imm = (opcode == OPC_OP_IMM) && ((f3_raw == 3'b001) || (f3_raw == 3'b101));

  // Route register indices and function fields according to format.
  always_comb begin
    rs1    = 5'd0;
    rs2    = 5'd0;
    rd     = 5'd0;
    funct3 = 3'd0;
    funct7 = 7'd0;
    if (fmt inside {FMT_I, FMT_S, FMT_B, FMT_R}) begin
      rs1    = ir[19:15];
      funct3 = f3_raw;
    end
    if (fmt inside {FMT_S, FMT_B, FMT_R}) rs2 = ir[24:20];
    if (fmt inside {FMT_U, FMT_J, FMT_I, FMT_R}) rd = ir[11:7];
    if ((fmt == FMT_R) || shift_imm) funct7 = f7_raw;
  end

  imm_gen u_imm_gen (
    .ir  (ir),
    .fmt (fmt),
    .imm (imm)
  );

`ifdef ID_ILLEGAL_CHECK_EN
  logic illegal_d;
  logic illegal_seen_q;

  // Flag encodings outside the supported RV32I subset.
  always_comb begin
    illegal_d = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: illegal_d = 1'b0;
      OPC_JALR:   illegal_d = (f3_raw != 3'b000);
      OPC_BRANCH: illegal_d = (f3_raw == 3'b010) || (f3_raw == 3'b011);
      OPC_LOAD:   illegal_d = (f3_raw == 3'b011) || (f3_raw == 3'b110) || (f3_raw == 3'b111);
      OPC_STORE:  illegal_d = (f3_raw >= 3'b011);
      OPC_OP:     illegal_d = !((f7_raw == 7'b0000000) ||
                                ((f7_raw == 7'b0100000) && ((f3_raw == 3'b000) || (f3_raw == 3'b101))));
      OPC_OP_IMM: illegal_d = ((f3_raw == 3'b001) && (f7_raw != 7'b0000000)) ||
                              ((f3_raw == 3'b101) && (f7_raw != 7'b0000000) && (f7_raw != 7'b0100000));
      default:    illegal_d = 1'b1;
    endcase
    if (ir[1:0] != 2'b11) illegal_d = 1'b1;
  end

  // Sticky capture of any illegal instruction presented at a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         illegal_seen_q <= 1'b0;
    else if (illegal_d) illegal_seen_q <= 1'b1;
  end

  assign illegal      = illegal_d;
  assign illegal_seen = illegal_seen_q;
  assign wr_reg_n     = !(writes_rd && (rd != 5'd0) && !illegal_d);
`else
  // Clock and reset have no load when the illegal check is compiled out.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  assign illegal      = 1'b0;
  assign illegal_seen = 1'b0;
  assign wr_reg_n     = !(writes_rd && (rd != 5'd0));
`endif

endmodule

// File: tb/tb_rv32i_decode.sv
module tb_rv32i_decode;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        wr_reg_n, illegal, illegal_seen;

  int n_cmp;
  int n_bad;

  rv32i_decode dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ir           (ir),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .imm          (imm),
    .wr_reg_n     (wr_reg_n),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ID_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        wr_n;
    logic        ill;
  } exp_t;

  // Reference decode written from the ISA rules, immediates by arithmetic.
  function automatic exp_t model(input logic [31:0] x);
    exp_t e;
    int unsigned op, f3, f7;
    int v;
    bit is_u, is_j, is_i, is_s, is_b, is_r, wr_op, bad;
    op = int'(x[6:0]); f3 = int'(x[14:12]); f7 = int'(x[31:25]);
    is_u = (op == 'h37) || (op == 'h17);
    is_j = (op == 'h6F);
    is_i = op inside {'h67, 'h03, 'h13, 'h0F, 'h73};
    is_b = (op == 'h63);
    is_s = (op == 'h23);
    is_r = (op == 'h33);
    wr_op = op inside {'h37, 'h17, 'h6F, 'h67, 'h03, 'h13, 'h33};
    v = 0;
    if (is_i) v = int'(x[30:20]) - (x[31] ? 2048 : 0);
    if (is_s) v = int'(x[30:25]) * 32 + int'(x[11:7]) - (x[31] ? 2048 : 0);
    if (is_b) v = int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2 - (x[31] ? 4096 : 0);
    if (is_u) v = int'(x[31:12]) * 4096;
    if (is_j) v = int'(x[19:12]) * 4096 + int'(x[20]) * 2048 + int'(x[30:21]) * 2 - (x[31] ? 1048576 : 0);
    e.imm = 32'(v);
    e.rs1 = (is_i || is_s || is_b || is_r) ? x[19:15] : 5'd0;
    e.rs2 = (is_s || is_b || is_r) ? x[24:20] : 5'd0;
    e.rd  = (is_u || is_j || is_i || is_r) ? x[11:7] : 5'd0;
    e.f3  = (is_i || is_s || is_b || is_r) ? x[14:12] : 3'd0;
    e.f7  = (is_r || (op == 'h13 && (f3 == 1 || f3 == 5))) ? x[31:25] : 7'd0;
    bad = !(is_u || is_j || is_i || is_b || is_s || is_r) || (x[1:0] != 2'b11);
    if (op == 'h67 && f3 != 0) bad = 1;
    if (is_b && (f3 == 2 || f3 == 3)) bad = 1;
    if (op == 'h03 && (f3 == 3 || f3 == 6 || f3 == 7)) bad = 1;
    if (is_s && f3 >= 3) bad = 1;
    if (is_r && !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)))) bad = 1;
    if (op == 'h13 && f3 == 1 && f7 != 0) bad = 1;
    if (op == 'h13 && f3 == 5 && !(f7 == 0 || f7 == 'h20)) bad = 1;
    e.ill  = CHECK_EN && bad;
    e.wr_n = !(wr_op && (e.rd != 0) && !e.ill);
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ir = 32'h0000_0013;
    #3;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_bad++; $display("FAIL reset_seen: got %b want 0", illegal_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Hand-encoded instructions with independently derived expected fields.
  task automatic test_directed();
    logic [31:0] t_ir   [10] = '{32'h000001B7, 32'h800001B7, 32'h002001EF, 32'h0020006F,
                                 32'h00208163, 32'h00208123, 32'h80108193, 32'h002081E7,
                                 32'h00208183, 32'h002081B3};
    logic [31:0] t_imm  [10] = '{32'h0, 32'h8000_0000, 32'h2, 32'h2, 32'h2, 32'h2,
                                 32'hFFFF_F801, 32'h2, 32'h2, 32'h0};
    logic [4:0]  t_rs1  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    logic [4:0]  t_rs2  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd2, 5'd0, 5'd0, 5'd0, 5'd2};
    logic [4:0]  t_rd   [10] = '{5'd3, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3};
    logic        t_wr   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ir = t_ir[i];
      #1;
      n_cmp++;
      if (opcode !== t_ir[i][6:0] || imm !== t_imm[i] || rs1 !== t_rs1[i] ||
          rs2 !== t_rs2[i] || rd !== t_rd[i] || wr_reg_n !== t_wr[i] || illegal !== 1'b0) begin
        n_bad++;
        $display("FAIL directed[%0d] ir=%h: got op=%b imm=%h rs1=%0d rs2=%0d rd=%0d wr_n=%b ill=%b want imm=%h rs1=%0d rs2=%0d rd=%0d wr_n=%b ill=0",
                 i, t_ir[i], opcode, imm, rs1, rs2, rd, wr_reg_n, illegal,
                 t_imm[i], t_rs1[i], t_rs2[i], t_rd[i], t_wr[i]);
      end
      if (i == 9 || i == 4) begin
        n_cmp++;
        if (funct3 !== 3'b000 || funct7 !== 7'b0000000) begin
          n_bad++; $display("FAIL directed_funct[%0d]: got f3=%b f7=%b want 000 0000000", i, funct3, funct7);
        end
      end
    end
  endtask

  task automatic test_illegal_seen();
    do_reset();
    @(negedge clk);
    ir = 32'h0000_0000;
    #1;
    n_cmp++;
    if (illegal !== CHECK_EN || wr_reg_n !== 1'b1 || illegal_seen !== 1'b0) begin
      n_bad++; $display("FAIL zero_ir: got ill=%b wr_n=%b seen=%b want ill=%b wr_n=1 seen=0",
                        illegal, wr_reg_n, illegal_seen, CHECK_EN);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (illegal_seen !== CHECK_EN) begin
      n_bad++; $display("FAIL seen_set: got %b want %b", illegal_seen, CHECK_EN);
    end
    ir = 32'h002081B3;
    @(posedge clk); #1;
    n_cmp++;
    if (illegal_seen !== CHECK_EN || illegal !== 1'b0) begin
      n_bad++; $display("FAIL seen_hold: got seen=%b ill=%b want seen=%b ill=0", illegal_seen, illegal, CHECK_EN);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (illegal_seen !== 1'b0) begin
      n_bad++; $display("FAIL seen_async_clr: got %b want 0", illegal_seen);
    end
    rst_n = 1'b1;
  endtask

  // Random instructions, biased toward known opcodes and common funct7 values.
  task automatic test_random();
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                             7'h13, 7'h33, 7'h0F, 7'h73};
    logic [31:0] x;
    exp_t e;
    logic seen_m;
    do_reset();
    seen_m = 1'b0;
    for (int i = 0; i < 400; i++) begin
      x = $urandom;
      if ($urandom_range(0, 9) < 8) x[6:0] = ops[$urandom_range(0, 10)];
      case ($urandom_range(0, 3))
        0: x[31:25] = 7'h00;
        1: x[31:25] = 7'h20;
        default: ;
      endcase
      @(negedge clk);
      ir = x;
      #1;
      e = model(x);
      n_cmp++;
      if (rs1 !== e.rs1 || rs2 !== e.rs2 || rd !== e.rd || opcode !== x[6:0] ||
          funct3 !== e.f3 || funct7 !== e.f7 || imm !== e.imm ||
          wr_reg_n !== e.wr_n || illegal !== e.ill || illegal_seen !== seen_m) begin
        n_bad++;
        $display("FAIL random[%0d] ir=%h: got rs1=%0d rs2=%0d rd=%0d op=%h f3=%b f7=%b imm=%h wr_n=%b ill=%b seen=%b want rs1=%0d rs2=%0d rd=%0d f3=%b f7=%b imm=%h wr_n=%b ill=%b seen=%b",
                 i, x, rs1, rs2, rd, opcode, funct3, funct7, imm, wr_reg_n, illegal, illegal_seen,
                 e.rs1, e.rs2, e.rd, e.f3, e.f7, e.imm, e.wr_n, e.ill, seen_m);
      end
      seen_m = seen_m | e.ill;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_illegal_seen();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_decode.md
# rv32i_decode

RV32I instruction-decode block for the in-order pipeline, between instruction fetch and execute. It splits the 32-bit instruction word into register indices, opcode and function fields. It also forms the sign-extended immediate for each format and generates the active-low register-write enable. The decode path is purely combinational; the clock and reset serve only the optional illegal-instruction status register.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- ir  in  32  instruction word
- rs1  out  5  source register 1 index
- rs2  out  5  source register 2 index
- rd  out  5  destination register index
- opcode  out  7  ir[6:0]
- funct3  out  3  function field
- funct7  out  7  function field
- imm  out  32  sign-extended immediate
- wr_reg_n  out  1  0 = instruction writes rd
- illegal  out  1  current ir is not a valid RV32I encoding
- illegal_seen  out  1  sticky registered copy of illegal

## Operation
- opcode = ir[6:0] always.
- Formats by opcode:
  - U: LUI 0110111, AUIPC 0010111
  - J: JAL 1101111
  - I: JALR 1100111, LOAD 0000011, OP-IMM 0010011, MISC-MEM 0001111, SYSTEM 1110011
  - B: BRANCH 1100011
  - S: STORE 0100011
  - R: OP 0110011
- imm by format:
  - I: sext(ir[31:20])
  - S: sext({ir[31:25], ir[11:7]})
  - B: sext({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0})
  - U: {ir[31:12], 12'b0}
  - J: sext({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0})
  - R and unknown: 0
- rs1 = ir[19:15] for I/S/B/R formats, else 0.
- rs2 = ir[24:20] for S/B/R formats, else 0.
- rd = ir[11:7] for U/J/I/R formats, else 0.
- funct3 = ir[14:12] for I/S/B/R formats, else 0.
- funct7 = ir[31:25] for R, and for OP-IMM with funct3 001 or 101; else 0.
- wr_reg_n = 0 only when all of these hold: opcode is LUI, AUIPC, JAL, JALR, LOAD, OP-IMM or OP; rd != 0; illegal = 0. Otherwise wr_reg_n = 1.
- illegal = 1 on any of:
  - ir[1:0] != 11
  - opcode outside the eleven listed
  - JALR with funct3 != 000
  - BRANCH with funct3 010 or 011
  - LOAD with funct3 011, 110 or 111
  - STORE with funct3 >= 011
  - OP with funct7 not 0000000, except funct7 0100000 with funct3 000 or 101
  - OP-IMM with funct3 001 and funct7 != 0000000
  - OP-IMM with funct3 101 and funct7 not 0000000 or 0100000
- Field outputs are still decoded normally when illegal = 1.

## Timing
- Every decode output, including illegal, is combinational from ir with zero latency and no dependence on clk or rst_n.
- illegal_seen:
  - rst_n low: cleared to 0 asynchronously.
  - Each rising clk edge: set to 1 if illegal = 1, otherwise holds.
  - Only rst_n clears it. Reset has priority over a simultaneous set.

## Configuration
- ID_ILLEGAL_CHECK_EN defined: illegal detection and the illegal_seen register are implemented as above.
- Undefined:
  - illegal and illegal_seen are tied to 0.
  - wr_reg_n ignores illegality.
  - Unknown opcodes still yield wr_reg_n = 1 and imm = 0.

## Structure
- Shared package holds the opcode localparams (OPC_LUI … OPC_SYSTEM) and a format enum (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X).
- One sub-module, imm_gen: inputs ir and format, output imm.

## Test plan
- LUI x3, 0 (ir = 32'h000001B7): opcode 0110111, rd 3, imm 0, wr_reg_n 0. Then LUI with ir[31:12] = 20'h80000: imm = 32'h8000_0000.
- JAL, ir[30:21] = 1, rd 3: imm 2, wr_reg_n 0. Same instruction with rd 0: rd 0, wr_reg_n 1.
- BEQ x1, x2, +2 (ir[11:8] = 0001): rs1 1, rs2 2, funct3 000, imm 2, rd 0, wr_reg_n 1. SB x2, 2(x1): imm 2, wr_reg_n 1.
- ADDI x3, x1, 12'h801: imm 32'hFFFF_F801, rs1 1, rd 3, wr_reg_n 0. JALR and LB with 12-bit immediate 2: imm 2.
- ADD x3, x1, x2 (ir = 32'h002081B3): funct7 0000000, funct3 000, rs2 2, wr_reg_n 0.
- With ID_ILLEGAL_CHECK_EN, apply ir = 32'h0000_0000:
  - illegal 1 and wr_reg_n 1 immediately.
  - illegal_seen rises at the next clk edge and stays 1 after a legal ir.
  - Asserting rst_n low mid-cycle clears it at once.
